// File: rtl/byte_decode_ctrl.sv
// Streaming ByteDecode_ELL controller: consumes encoded bytes LSB-first and
// emits ELL-bit coefficients one per handshake, reduced mod Q when ELL==12.
module byte_decode_ctrl #(
  parameter int unsigned ELL        = 12,
  parameter int unsigned NUM_COEFFS = 256,
  parameter int unsigned Q          = 3329
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ELL-1:0]                out_coeff,
  output logic [$clog2(NUM_COEFFS)-1:0] out_idx
);

  localparam int unsigned NUM_BYTES = NUM_COEFFS * ELL / 8;
  localparam int unsigned BUF_W     = ELL + 7;
  localparam int unsigned BC_W      = $clog2(ELL + 8);
  localparam int unsigned BYTE_W    = $clog2(NUM_BYTES + 1);
  localparam int unsigned IDX_W     = $clog2(NUM_COEFFS);
  localparam bit          REDUCE    = (ELL == 12);
  localparam logic [ELL-1:0] Q_L    = ELL'(Q);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   bit_buf_q, bit_buf_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]   coeff_cnt_q, coeff_cnt_d;
  logic               done_q, done_d;
  logic [ELL-1:0]     raw;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_buf_q   <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      coeff_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_buf_q   <= bit_buf_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      coeff_cnt_q <= coeff_cnt_d;
      done_q      <= done_d;
    end
  end

  // Next state, handshakes and bit-buffer update; in_ready/out_valid are exclusive
  always_comb begin
    state_d     = state_q;
    bit_buf_d   = bit_buf_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    coeff_cnt_d = coeff_cnt_q;
    done_d      = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          bit_buf_d   = '0;
          bit_cnt_d   = '0;
          byte_cnt_d  = '0;
          coeff_cnt_d = '0;
        end
      end
      RUN: begin
        in_ready  = (bit_cnt_q < BC_W'(ELL)) && (byte_cnt_q < BYTE_W'(NUM_BYTES));
        out_valid = (bit_cnt_q >= BC_W'(ELL));
        if (in_valid && in_ready) begin
          bit_buf_d  = bit_buf_q | (BUF_W'(in_byte) << bit_cnt_q);
          bit_cnt_d  = bit_cnt_q + BC_W'(8);
          byte_cnt_d = byte_cnt_q + BYTE_W'(1);
        end else if (out_valid && out_ready) begin
          bit_buf_d   = bit_buf_q >> ELL;
          bit_cnt_d   = bit_cnt_q - BC_W'(ELL);
          coeff_cnt_d = coeff_cnt_q + IDX_W'(1);
          if (coeff_cnt_q == IDX_W'(NUM_COEFFS - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  assign raw = bit_buf_q[ELL-1:0];

  // Raw value is below 2Q, so one conditional subtract completes the reduction
  always_comb begin
    out_coeff = raw;
    if (REDUCE && (raw >= Q_L)) out_coeff = raw - Q_L;
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign out_idx = coeff_cnt_q;

endmodule

// File: tb/tb_byte_decode_ctrl.sv
// Self-checking bench for byte_decode_ctrl at ELL=1, 4 and 12: directed table,
// randomized streams against a bit-level reference, and stall/restart/reset sequences.
module tb_byte_decode_ctrl;

  localparam int NC = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s     [3];
  logic       in_valid_s  [3];
  logic       out_ready_s [3];
  logic [7:0] in_byte_s   [3];
  logic       busy_w      [3];
  logic       done_w      [3];
  logic       in_ready_w  [3];
  logic       out_valid_w [3];
  logic [7:0] idx_w       [3];
  logic [11:0] coeff_w    [3];
  logic [0:0] c0;
  logic [3:0] c1;
  logic [11:0] c2;

  logic [7:0] src_bytes [0:383];
  int cap_coeff [NC];
  int cap_idx   [NC];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign coeff_w[0] = 12'(c0);
  assign coeff_w[1] = 12'(c1);
  assign coeff_w[2] = c2;

  byte_decode_ctrl #(.ELL(1), .NUM_COEFFS(256), .Q(3329)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .busy(busy_w[0]), .done(done_w[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]), .in_byte(in_byte_s[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]), .out_coeff(c0), .out_idx(idx_w[0]));

  byte_decode_ctrl #(.ELL(4), .NUM_COEFFS(256), .Q(3329)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .busy(busy_w[1]), .done(done_w[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]), .in_byte(in_byte_s[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]), .out_coeff(c1), .out_idx(idx_w[1]));

  byte_decode_ctrl #(.ELL(12), .NUM_COEFFS(256), .Q(3329)) u_d12 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .busy(busy_w[2]), .done(done_w[2]),
    .in_valid(in_valid_s[2]), .in_ready(in_ready_w[2]), .in_byte(in_byte_s[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready_s[2]), .out_coeff(c2), .out_idx(idx_w[2]));

  function automatic int ell_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 12;
    endcase
  endfunction

  // Reference: view the byte stream as a flat bit array, gather ELL bits, reduce mod Q
  function automatic int model_coeff(input int ell, input int j);
    int v = 0;
    int p;
    for (int b = 0; b < ell; b++) begin
      p = j * ell + b;
      if (src_bytes[p / 8][p % 8]) v += (1 << b);
    end
    if (ell == 12) v = v % 3329;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 384; i++) src_bytes[i] = 8'($urandom);
  endtask

  task automatic check_model(input int k, input string tag);
    for (int j = 0; j < NC; j++) begin
      check($sformatf("%s_coeff%0d", tag, j), cap_coeff[j], model_coeff(ell_of(k), j));
      check($sformatf("%s_idx%0d", tag, j), cap_idx[j], j);
    end
  endtask

  task automatic check_totals(input int k, input string tag, input int ncoef, input int nbytes, input int ndone);
    check($sformatf("%s_ncoef", tag), ncoef, NC);
    check($sformatf("%s_nbytes", tag), nbytes, NC * ell_of(k) / 8);
    check($sformatf("%s_ndone", tag), ndone, 1);
  endtask

  // Drive one decode on DUT k from src_bytes, capturing handshaken coefficients
  task automatic run_decode(input int k, input bit rand_stall, input int stall_at,
                            input int start_at, input int rst_at, input bit chain,
                            input bit skip_start, output int ncoef, output int nbytes,
                            output int ndone, output bit aborted);
    int tail;
    bit stall_done, start_done, fin;
    logic [11:0] hc;
    logic [7:0]  hi;
    ncoef = 0; nbytes = 0; ndone = 0; aborted = 1'b0;
    stall_done = 1'b0; start_done = 1'b0; fin = 1'b0; tail = 0;
    if (!skip_start) begin
      start_s[k] = 1'b1;
      @(negedge clk);
      start_s[k] = 1'b0;
    end
    check($sformatf("busy_run_d%0d", k), int'(busy_w[k]), 1);
    for (int cyc = 0; cyc < 6000 && !fin; cyc++) begin
      start_s[k] = 1'b0;
      if (done_w[k]) begin
        ndone++;
        if (ndone == 1) check($sformatf("busy_at_done_d%0d", k), int'(busy_w[k]), 0);
      end
      if (ndone > 0) begin
        in_valid_s[k]  = 1'b0;
        out_ready_s[k] = 1'b0;
        if (chain && tail == 0) start_s[k] = 1'b1;
        tail++;
        if (tail > 3) fin = 1'b1;
      end else begin
        if (rst_at >= 0 && ncoef == rst_at) begin
          rst_n = 1'b0;
          #1;
          check("rst_busy", int'(busy_w[k]), 0);
          check("rst_done", int'(done_w[k]), 0);
          check("rst_in_ready", int'(in_ready_w[k]), 0);
          check("rst_out_valid", int'(out_valid_w[k]), 0);
          check("rst_coeff", int'(coeff_w[k]), 0);
          check("rst_idx", int'(idx_w[k]), 0);
          in_valid_s[k]  = 1'b0;
          out_ready_s[k] = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          @(negedge clk);
          check("rst_no_done", int'(done_w[k]), 0);
          check("rst_idle", int'(busy_w[k]), 0);
          aborted = 1'b1;
          return;
        end
        if (stall_at >= 0 && !stall_done && ncoef == stall_at && out_valid_w[k]) begin
          hc = coeff_w[k];
          hi = idx_w[k];
          out_ready_s[k] = 1'b0;
          in_valid_s[k]  = 1'b1;
          for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            check("stall_coeff", int'(coeff_w[k]), int'(hc));
            check("stall_idx", int'(idx_w[k]), int'(hi));
            check("stall_in_ready", int'(in_ready_w[k]), 0);
            check("stall_out_valid", int'(out_valid_w[k]), 1);
          end
          stall_done = 1'b1;
        end
        if (start_at >= 0 && !start_done && ncoef == start_at) begin
          start_s[k] = 1'b1;
          start_done = 1'b1;
        end
        in_valid_s[k]  = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        out_ready_s[k] = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_byte_s[k]   = (nbytes < 384) ? src_bytes[nbytes] : 8'h00;
        if (in_valid_s[k] && in_ready_w[k]) nbytes++;
        if (out_ready_s[k] && out_valid_w[k]) begin
          if (ncoef < NC) begin
            cap_coeff[ncoef] = int'(coeff_w[k]);
            cap_idx[ncoef]   = int'(idx_w[k]);
          end
          ncoef++;
        end
      end
      @(negedge clk);
    end
    if (!fin) check($sformatf("timeout_d%0d", k), 0, 1);
    if (chain) check($sformatf("chain_busy_d%0d", k), int'(busy_w[k]), 1);
    start_s[k]     = 1'b0;
    in_valid_s[k]  = 1'b0;
    out_ready_s[k] = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic [47:0] head;
    logic [7:0]  fill;
    int          e0, e1, e2, e3;
    int          rest;
    bit          stall;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int ncoef, nbytes, ndone;
    bit aborted;
    logic [47:0] h;
    int expv;

    vecs[0] = '{0, 48'hFFFF_FFFF_FFFF, 8'hFF, 1, 1, 1, 1, 1, 1'b0};
    vecs[1] = '{1, 48'h0000_0000_0021, 8'h00, 1, 2, 0, 0, 0, 1'b0};
    vecs[2] = '{2, 48'h0012_3400_0FFF, 8'h00, 766, 0, 564, 1, 0, 1'b0};
    vecs[3] = '{2, 48'hFFFF_FFFF_FFFF, 8'hFF, 766, 766, 766, 766, 766, 1'b1};
    vecs[4] = '{0, 48'h0000_0000_0000, 8'h00, 0, 0, 0, 0, 0, 1'b1};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_s[k] = 1'b0; in_valid_s[k] = 1'b0; out_ready_s[k] = 1'b0; in_byte_s[k] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_busy_d%0d", k), int'(busy_w[k]), 0);
      check($sformatf("reset_done_d%0d", k), int'(done_w[k]), 0);
      check($sformatf("reset_out_valid_d%0d", k), int'(out_valid_w[k]), 0);
      check($sformatf("reset_coeff_d%0d", k), int'(coeff_w[k]), 0);
      check($sformatf("reset_idx_d%0d", k), int'(idx_w[k]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Bytes offered while idle must not be taken
    for (int k = 0; k < 3; k++) in_valid_s[k] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("idle_in_ready_d%0d", k), int'(in_ready_w[k]), 0);
      check($sformatf("idle_busy_d%0d", k), int'(busy_w[k]), 0);
      in_valid_s[k] = 1'b0;
    end

    for (int r = 0; r < 5; r++) begin
      h = vecs[r].head;
      for (int i = 0; i < 384; i++) src_bytes[i] = (i < 6) ? h[i*8 +: 8] : vecs[r].fill;
      run_decode(vecs[r].k, vecs[r].stall, -1, -1, -1, 1'b0, 1'b0, ncoef, nbytes, ndone, aborted);
      check_totals(vecs[r].k, $sformatf("vec%0d", r), ncoef, nbytes, ndone);
      for (int j = 0; j < NC; j++) begin
        case (j)
          0:       expv = vecs[r].e0;
          1:       expv = vecs[r].e1;
          2:       expv = vecs[r].e2;
          3:       expv = vecs[r].e3;
          default: expv = vecs[r].rest;
        endcase
        check($sformatf("vec%0d_coeff%0d", r, j), cap_coeff[j], expv);
        check($sformatf("vec%0d_idx%0d", r, j), cap_idx[j], j);
      end
    end

    for (int k = 0; k < 3; k++) begin
      fill_random();
      run_decode(k, 1'b1, -1, -1, -1, 1'b0, 1'b0, ncoef, nbytes, ndone, aborted);
      check_totals(k, $sformatf("rand_d%0d", k), ncoef, nbytes, ndone);
      check_model(k, $sformatf("rand_d%0d", k));
    end

    fill_random();
    run_decode(2, 1'b1, 5, -1, -1, 1'b0, 1'b0, ncoef, nbytes, ndone, aborted);
    check_totals(2, "stall", ncoef, nbytes, ndone);
    check_model(2, "stall");

    fill_random();
    run_decode(2, 1'b1, -1, 50, -1, 1'b0, 1'b0, ncoef, nbytes, ndone, aborted);
    check_totals(2, "restart", ncoef, nbytes, ndone);
    check_model(2, "restart");

    fill_random();
    run_decode(2, 1'b1, -1, -1, 100, 1'b0, 1'b0, ncoef, nbytes, ndone, aborted);
    check("reset_abort", int'(aborted), 1);
    check("reset_abort_ndone", ndone, 0);
    fill_random();
    run_decode(2, 1'b1, -1, -1, -1, 1'b0, 1'b0, ncoef, nbytes, ndone, aborted);
    check_totals(2, "post_reset", ncoef, nbytes, ndone);
    check_model(2, "post_reset");

    // start in the done cycle launches the next decode back to back
    fill_random();
    run_decode(1, 1'b1, -1, -1, -1, 1'b1, 1'b0, ncoef, nbytes, ndone, aborted);
    check_totals(1, "chain_a", ncoef, nbytes, ndone);
    check_model(1, "chain_a");
    fill_random();
    run_decode(1, 1'b1, -1, -1, -1, 1'b0, 1'b1, ncoef, nbytes, ndone, aborted);
    check_totals(1, "chain_b", ncoef, nbytes, ndone);
    check_model(1, "chain_b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/byte_decode_ctrl.md
Name: byte_decode_ctrl

Overview:
- Sequential streaming ByteDecode_ELL controller for the Kyber-768-90s datapath.
- Accepts a serialized encoded polynomial of NUM_COEFFS*ELL/8 bytes over a valid/ready input stream.
- Emits NUM_COEFFS coefficients of ELL bits each, one per handshake, LSB-first bit order.
- Sits between the byte-oriented input buffers (public key, ciphertext, secret key) and polynomial RAM write ports; replaces the flat 256-coefficient combinational decoder on area-constrained paths.

Parameters:
ELL, 12, coefficient width in bits (1..12); ELL=12 enables reduction mod Q.
NUM_COEFFS, 256, coefficients per polynomial; NUM_COEFFS*ELL must be a multiple of 8.
Q, 3329, Kyber modulus, applied only when ELL==12.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle pulse; begins a decode when idle.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse after the last coefficient handshake.
in_valid  in  1  input byte valid.
in_ready  out  1  controller can accept a byte this cycle.
in_byte  in  8  encoded byte; bit 0 is the earliest stream bit.
out_valid  out  1  out_coeff holds a valid coefficient.
out_ready  in  1  downstream accepts the coefficient.
out_coeff  out  ELL  decoded coefficient.
out_idx  out  $clog2(NUM_COEFFS)  index of the current coefficient (0..NUM_COEFFS-1).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, in_ready=0, out_valid=0, out_coeff=0, out_idx=0. Bit buffer, bit count, and byte counter cleared. Reset mid-decode abandons the polynomial with no done pulse.
- State IDLE: in_ready=0, out_valid=0. When start=1, go to RUN next cycle and clear bit_cnt, byte_cnt, and coeff_cnt.
- State RUN: busy=1. start is ignored.
- Bit buffer: register buf of width ELL+7 bits with bit count bit_cnt (0..ELL+7).
- in_ready = RUN && bit_cnt<ELL && byte_cnt<NUM_COEFFS*ELL/8.
- On input handshake: buf[bit_cnt +: 8] <= in_byte; bit_cnt += 8; byte_cnt += 1.
- out_valid = RUN && bit_cnt>=ELL. out_valid and in_ready are mutually exclusive by construction, so there are no simultaneous input/output events.
- Raw coefficient r = buf[ELL-1:0].
  - ELL==12: out_coeff = (r>=Q) ? r-Q : r. A single conditional subtract suffices since r<4096<2Q.
  - Otherwise: out_coeff = r.
- out_coeff is combinational from registered buf; no extra latency.
- On output handshake: buf >>= ELL; bit_cnt -= ELL; coeff_cnt += 1.
- out_idx = coeff_cnt.
- With out_ready=0, out_valid, out_coeff, and out_idx stay stable; no input is accepted while bit_cnt>=ELL.
- On the handshake of coefficient NUM_COEFFS-1: next cycle state=IDLE, done=1 for exactly one cycle, busy=0.
- Bit accounting: total input bits equal NUM_COEFFS*ELL exactly, so bit_cnt==0 at completion; no residual bits.
- Latency:
  - First out_valid follows ceil(ELL/8) accepted bytes, registered one cycle after the enabling byte handshake.
  - With in_valid and out_ready tied high, a decode takes NUM_COEFFS*ELL/8 + NUM_COEFFS cycles plus 1 start cycle.
- start asserted in the same cycle as done: accepted (state is IDLE in that cycle).
- Bytes presented with in_valid while IDLE are not consumed (in_ready=0).

Test Plan:
- ELL=1, start, then 32 bytes of 0xFF, out_ready=1 -> 256 coefficients all 1, out_idx 0..255, done pulses once, busy falls with done.
- ELL=4, first byte 0x21, rest 0x00 -> coeff0=1, coeff1=2, coeff2..255=0; exactly 128 bytes accepted.
- ELL=12, bytes FF 0F 00 34 12 00 ... -> coeff0=4095-3329=766, coeff1=0, coeff2=0x234=564, coeff3=0x001; 384 bytes accepted, 256 coefficients emitted.
- ELL=12, out_ready low for 10 cycles while out_valid=1 -> out_coeff and out_idx unchanged, in_ready=0 throughout; decode resumes correctly with a random out_ready/in_valid stall pattern, and results match a software ByteDecode model.
- start pulsed again mid-RUN -> ignored; coeff count and byte count unaffected; single done pulse.
- rst_n low at coefficient 100 -> all outputs at reset values immediately (async), no done pulse. A new start then decodes a full polynomial correctly from byte 0.
